// File: rtl/pipe_hazard_pkg.sv
// Shared stage indices, divide-unit FSM states and defaults for the
// pipeline hazard controller.
package pipe_hazard_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int MD_LATENCY_DEF = 8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_counter.sv
// Multicycle-divide occupancy counter: holds E for LATENCY-1 cycles
// starting with the cycle the op is launched.
module md_busy_counter
  import pipe_hazard_pkg::*;
#(
  parameter int LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic stall
);

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(LATENCY - 2);

  md_state_t     state;
  logic [CW-1:0] cnt;

  // BUSY ends on the edge where the counter would reach zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !abort && (LOAD != '0)) begin
            state <= MD_BUSY;
            cnt   <= LOAD;
          end
        end
        MD_BUSY: begin
          if (abort || (cnt == CW'(1))) begin
            state <= MD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state == MD_BUSY);
  assign stall = busy | (start & ~abort);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Per-stage stall/flush generation, valid tracking and divide hold for the
// integer pipeline. Perf counters exist only with PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int E_STAGE    = STG_E,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] StallReq,
  input  logic [NUM_STAGES-1:0] FlushReq,
  input  logic                  InstrValidF,
  input  logic                  MdStartE,
  output logic [NUM_STAGES-1:0] Stall,
  output logic [NUM_STAGES-1:0] Flush,
  output logic [NUM_STAGES-1:0] ValidQ,
  output logic                  MdBusyE,
  output logic [CNT_W-1:0]      RetireCnt,
  output logic [CNT_W-1:0]      StallCycCnt
);

  logic [NUM_STAGES-1:0] raw;
  logic [NUM_STAGES-1:0] prev;
  logic                  acc;
  logic                  md_stall;
  logic                  md_busy;

  md_busy_counter #(
    .LATENCY(MD_LATENCY)
  ) u_md (
    .clk  (clk),
    .reset(reset),
    .start(MdStartE),
    .abort(FlushReq[E_STAGE]),
    .busy (md_busy),
    .stall(md_stall)
  );

  // A stall anywhere downstream freezes every stage behind it
  always_comb begin
    raw = '0;
    acc = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      acc    = acc | StallReq[i];
      raw[i] = acc | (md_stall && (i <= E_STAGE));
    end
  end

  assign Stall = raw & ~FlushReq;
  assign Flush = FlushReq |
                 ({raw[NUM_STAGES-2:0], 1'b0} & ~Stall);

  assign prev    = {ValidQ[NUM_STAGES-2:0], InstrValidF};
  assign MdBusyE = md_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidQ <= '0;
    end else begin
      ValidQ <= (ValidQ & Stall) |
                (prev & ~Stall & ~Flush);
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] retire_q;
  logic [CNT_W-1:0] stcyc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
      stcyc_q  <= '0;
    end else begin
      if (ValidQ[NUM_STAGES-1] && !Stall[NUM_STAGES-1] &&
          !FlushReq[NUM_STAGES-1])
        retire_q <= retire_q + CNT_W'(1);
      if (Stall[0])
        stcyc_q <= stcyc_q + CNT_W'(1);
    end
  end

  assign RetireCnt   = retire_q;
  assign StallCycCnt = stcyc_q;
`else
  assign RetireCnt   = '0;
  assign StallCycCnt = '0;
`endif

endmodule
